uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning number of requesters (2..8).
REQ-002 The block SHALL have parameter ACK_WIN, default 16, meaning clk cycles after frame end during which nack is accepted.
REQ-003 The block SHALL have parameter MAX_RETRY, default 3, meaning retransmissions allowed per frame (1..15).
REQ-004 The block SHALL have ports:
  clk  in  1  single system clock, rising edge
  reset  in  1  synchronous, active-high
  req  in  NUM_REQ  per-requester frame request, level
  req_data  in  8*NUM_REQ  byte i at bits [8i+7:8i]
  grant  out  NUM_REQ  one-hot, one-cycle pulse: request accepted, data captured
  done  out  NUM_REQ  one-hot, one-cycle pulse: frame finished
  err  out  1  one-cycle pulse: retries exhausted, frame dropped
  nack  in  1  far end rejected last frame
  tx_send  out  1  send strobe to UART transmitter
  tx_load  out  1  resend-stored-packet strobe to UART transmitter
  tx_data  out  8  byte to UART transmitter
  tx_busy  in  1  UART transmitter busy

Function
REQ-005 The FSM SHALL have states IDLE, SEND, WAIT_TX, ACK_WAIT, RELOAD.
REQ-006 IDLE: when any req bit is high, the block SHALL select by round robin starting at last-granted index + 1, wrapping NUM_REQ-1 -> 0, capture that byte into tx_data, pulse grant[i], and enter SEND.
REQ-007 SEND SHALL assert tx_send for exactly one cycle, clear the retry count, then enter WAIT_TX.
REQ-008 RELOAD SHALL assert tx_load for exactly one cycle, increment the retry count, then enter WAIT_TX.
REQ-009 WAIT_TX SHALL ignore tx_busy in its first cycle (blanking), then leave when tx_busy is low.
REQ-010 Leaving WAIT_TX SHALL go to ACK_WAIT with the window counter loaded to ACK_WIN.
REQ-011 ACK_WAIT: nack high with retry count < MAX_RETRY SHALL go to RELOAD.
REQ-012 ACK_WAIT: nack high with retry count = MAX_RETRY SHALL pulse err, pulse done[i], and go to IDLE.
REQ-013 ACK_WAIT: window counter reaching 0 without nack SHALL pulse done[i] and go to IDLE.
REQ-014 nack outside ACK_WAIT SHALL be ignored.
REQ-015 tx_data SHALL hold stable from grant until the FSM returns to IDLE.
REQ-016 A req deasserted after grant SHALL NOT abort the frame.
REQ-017 Requests arriving in non-IDLE states SHALL wait; no request is lost while held high.
REQ-018 Latency: req sampled high in IDLE at edge n SHALL produce grant at cycle n+1 and tx_send at n+2.
REQ-019 grant, done, err, tx_send and tx_load SHALL be registered and never overlap incorrectly; tx_send and tx_load SHALL never be high together.

Reset
REQ-020 Reset SHALL be synchronous, active-high, and dominate all other inputs.
REQ-021 On reset the block SHALL enter IDLE with all outputs 0, tx_data 8'h00, retry and window counters 0, and the last-granted pointer NUM_REQ-1, so requester 0 wins first.
REQ-022 Reset mid-frame SHALL abandon the frame without a done or err pulse.

Configuration
REQ-023 Macro UART_TX_ARB_RETRY_EN defined: REQ-008 and REQ-010 to REQ-014 SHALL apply.
REQ-024 UART_TX_ARB_RETRY_EN undefined: RELOAD and ACK_WAIT SHALL be absent, nack ignored, tx_load and err tied 0, and WAIT_TX exit SHALL pulse done[i] and return to IDLE.

Structure
REQ-025 Package uart_tx_arb_pkg SHALL hold the state enum, the retry-count width (4), and the window-count width function.
REQ-026 Sub-module rr_picker (combinational one-hot round-robin select from req and pointer) SHALL be instantiated once.

Verification
REQ-027 Single req[0], byte 8'hA5, no nack: grant[0] at n+1, tx_send at n+2, tx_data=8'hA5, done[0] ACK_WIN cycles after tx_busy falls.
REQ-028 req=4'b1111 held: grants SHALL go 0,1,2,3,0 in order, with one frame per grant.
REQ-029 nack pulsed in ACK_WAIT once: exactly one tx_load, a second frame of the same byte, then done[i] with no err.
REQ-030 nack on every window, MAX_RETRY=3: three tx_load pulses, then err and done[i] together, then return to IDLE.
REQ-031 Reset asserted during WAIT_TX: next cycle all outputs 0, no done; a subsequent req[2] only SHALL be granted 2.
REQ-032 Build without UART_TX_ARB_RETRY_EN and pulse nack: no tx_load, and done immediately after tx_busy falls.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and sizing helpers for the UART transmit arbiter.
package uart_tx_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_TX,
    ACK_WAIT,
    RELOAD
  } state_e;

  // Width of the retransmission counter.
  localparam int RETRY_W = 4;

  // Bits needed to hold an acknowledge-window count of n.
  function automatic int win_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: combinational one-hot round-robin select. The search starts
// at ptr_i + 1 and wraps, so the last-granted requester has lowest priority.
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  logic [PW-1:0] cand;
  logic          found;

  // Walk the requesters in priority order; the first one set wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = PW'((int'(ptr_i) + k) % N);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding bytes from NUM_REQ
// requesters into a single UART transmitter.
// Optional feature macro UART_TX_ARB_RETRY_EN: adds a post-frame acknowledge
// window in which nack triggers a resend (tx_load), up to MAX_RETRY times,
// after which the frame is dropped with err. Without it, a frame is done as
// soon as the transmitter goes idle and nack is ignored.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ACK_WIN   = 16,
  parameter int MAX_RETRY = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic                 err,
  input  logic                 nack,
  output logic                 tx_send,
  output logic                 tx_load,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [7:0]           data_q, data_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 err_q, err_d;
  logic                 send_q, send_d;
  logic                 load_q, load_d;
  logic                 blank_q, blank_d;

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [PW-1:0]        pick_idx;
  logic                 pick_any;
  logic [NUM_REQ-1:0]   cur_oh;

`ifdef UART_TX_ARB_RETRY_EN
  localparam int WW = win_w(ACK_WIN);
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [WW-1:0]        win_q, win_d;
`else
  // Retry feature compiled out: keep the config visible but inert.
  localparam int UNUSED_CFG = ACK_WIN + MAX_RETRY;
  logic unused_nack;
  assign unused_nack = nack;
`endif

  rr_picker #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // ptr_q always names the requester owning the frame in flight.
  assign cur_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << ptr_q;

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    grant_d = '0;
    done_d  = '0;
    err_d   = 1'b0;
    send_d  = 1'b0;
    load_d  = 1'b0;
    blank_d = 1'b0;
`ifdef UART_TX_ARB_RETRY_EN
    retry_d = retry_q;
    win_d   = win_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_gnt;
          ptr_d   = pick_idx;
          data_d  = req_data[{pick_idx, 3'b000} +: 8];
          state_d = SEND;
        end
      end
      SEND: begin
        send_d  = 1'b1;
        blank_d = 1'b1;
        state_d = WAIT_TX;
`ifdef UART_TX_ARB_RETRY_EN
        retry_d = '0;
`endif
      end
      WAIT_TX: begin
        // blank_q covers the cycle before the transmitter can raise busy.
        if (!blank_q && !tx_busy) begin
`ifdef UART_TX_ARB_RETRY_EN
          win_d   = WW'(ACK_WIN);
          state_d = ACK_WAIT;
`else
          done_d  = cur_oh;
          state_d = IDLE;
`endif
        end
      end
`ifdef UART_TX_ARB_RETRY_EN
      ACK_WAIT: begin
        win_d = win_q - WW'(1);
        if (nack) begin
          if (retry_q < RETRY_W'(MAX_RETRY)) begin
            state_d = RELOAD;
          end else begin
            err_d   = 1'b1;
            done_d  = cur_oh;
            state_d = IDLE;
          end
        end else if (win_q <= WW'(1)) begin
          done_d  = cur_oh;
          state_d = IDLE;
        end
      end
      RELOAD: begin
        load_d  = 1'b1;
        blank_d = 1'b1;
        retry_d = retry_q + RETRY_W'(1);
        state_d = WAIT_TX;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any frame silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= PW'(NUM_REQ - 1);
      data_q  <= 8'h00;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      send_q  <= 1'b0;
      load_q  <= 1'b0;
      blank_q <= 1'b0;
`ifdef UART_TX_ARB_RETRY_EN
      retry_q <= '0;
      win_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      send_q  <= send_d;
      load_q  <= load_d;
      blank_q <= blank_d;
`ifdef UART_TX_ARB_RETRY_EN
      retry_q <= retry_d;
      win_q   <= win_d;
`endif
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign err     = err_q;
  assign tx_send = send_q;
  assign tx_load = load_q;
  assign tx_data = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (default parameters).
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int MR = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   grant, done;
  logic           err, nack = 1'b0;
  logic           tx_send, tx_load, tx_busy = 1'b0;
  logic [7:0]     tx_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] bytes_t [N] = '{8'hA5, 8'h5A, 8'h3C, 8'h44};

  uart_tx_arbiter #(.NUM_REQ(N), .ACK_WIN(AW), .MAX_RETRY(MR)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .done     (done),
    .err      (err),
    .nack     (nack),
    .tx_send  (tx_send),
    .tx_load  (tx_load),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_send"}, 32'(tx_send), 0);
    chk({tag, "_load"}, 32'(tx_load), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_grant(input int bound, output logic [N-1:0] gv);
    gv = '0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (grant != '0) begin
        gv = grant;
        break;
      end
    end
  endtask

  task automatic run_to_done(input int bound, output int loads, output int errs,
                             output logic [N-1:0] dv, output logic err_at_done);
    loads = 0;
    errs = 0;
    dv = '0;
    err_at_done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      chk("send_load_excl", 32'(tx_send & tx_load), 0);
      if (tx_load) loads++;
      if (err) errs++;
      if (done != '0) begin
        dv = done;
        err_at_done = err;
        break;
      end
    end
  endtask

  initial begin
    logic [N-1:0] gv, dv;
    int loads, errs;
    logic ead;

    for (int i = 0; i < N; i++) req_data[8*i +: 8] = bytes_t[i];

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    chk_quiet("rst");
    chk("rst_data", 32'(tx_data), 32'h00);
    reset = 1'b0;
    tick();

    // Single requester 0: latency, data capture, done timing
    req = 4'b0001;
    tick();
    chk("A_grant", 32'(grant), 32'b0001);
    chk("A_send_early", 32'(tx_send), 0);
    chk("A_data_at_grant", 32'(tx_data), 32'hA5);
    req = '0;
    tick();
    chk("A_send", 32'(tx_send), 1);
    chk("A_grant_pulse", 32'(grant), 0);
    tx_busy = 1'b1;
    tick();
    chk("A_send_pulse", 32'(tx_send), 0);
    tick();
    chk("A_no_done_busy", 32'(done), 0);
    tx_busy = 1'b0;
`ifdef UART_TX_ARB_RETRY_EN
    tick();
    chk("A_win_start", 32'(done), 0);
    repeat (AW - 1) tick();
    chk("A_win_end_minus1", 32'(done), 0);
    tick();
`else
    tick();
`endif
    chk("A_done", 32'(done), 32'b0001);
    chk("A_err", 32'(err), 0);
    chk("A_load", 32'(tx_load), 0);
    chk("A_data_held", 32'(tx_data), 32'hA5);
    tick();
    chk("A_done_pulse", 32'(done), 0);

    // All requesting: round robin 0,1,2,3,0, one frame per grant
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_grant(60, gv);
      chk("B_grant", 32'(gv), 32'(1) << (g % N));
      chk("B_data", 32'(tx_data), 32'(bytes_t[g % N]));
      run_to_done(60, loads, errs, dv, ead);
      chk("B_done", 32'(dv), 32'(1) << (g % N));
      chk("B_err", 32'(errs), 0);
    end
    req = '0;
    tick();
    tick();

`ifndef UART_TX_ARB_RETRY_EN
    // nack ignored, done right after busy falls, blanking cycle honoured
    do_reset();
    req = 4'b0100;
    nack = 1'b1;
    tick();
    chk("C_grant", 32'(grant), 32'b0100);
    req = '0;
    tick();
    chk("C_send", 32'(tx_send), 1);
    chk("C_data", 32'(tx_data), 32'h3C);
    tick();
    chk("C_blank", 32'(done), 0);
    tick();
    chk("C_done", 32'(done), 32'b0100);
    chk("C_load", 32'(tx_load), 0);
    chk("C_err", 32'(err), 0);
    nack = 1'b0;
    tick();
`else
    // Single nack: one resend of the same byte, then done without err
    do_reset();
    req = 4'b0010;
    tick();
    chk("R1_grant", 32'(grant), 32'b0010);
    req = '0;
    tick();
    chk("R1_send", 32'(tx_send), 1);
    tick();
    tick();
    nack = 1'b1;
    tick();
    nack = 1'b0;
    chk("R1_load_early", 32'(tx_load), 0);
    tick();
    chk("R1_load", 32'(tx_load), 1);
    chk("R1_send_off", 32'(tx_send), 0);
    chk("R1_data", 32'(tx_data), 32'h5A);
    run_to_done(100, loads, errs, dv, ead);
    chk("R1_more_loads", 32'(loads), 0);
    chk("R1_errs", 32'(errs), 0);
    chk("R1_done", 32'(dv), 32'b0010);

    // nack every window: MR resends, then err with done
    do_reset();
    req = 4'b0010;
    nack = 1'b1;
    tick();
    chk("R2_grant", 32'(grant), 32'b0010);
    req = '0;
    run_to_done(200, loads, errs, dv, ead);
    chk("R2_loads", 32'(loads), MR);
    chk("R2_errs", 32'(errs), 1);
    chk("R2_err_with_done", 32'(ead), 1);
    chk("R2_done", 32'(dv), 32'b0010);
    nack = 1'b0;
    tick();
    chk_quiet("R2_after");
`endif

    // Reset in WAIT_TX abandons the frame; pointer restarts
    do_reset();
    req = 4'b0001;
    tick();
    chk("D_grant0", 32'(grant), 32'b0001);
    req = '0;
    tick();
    tx_busy = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    chk_quiet("D_rst");
    chk("D_rst_data", 32'(tx_data), 32'h00);
    reset = 1'b0;
    tx_busy = 1'b0;
    req = 4'b0100;
    tick();
    chk("D_grant2", 32'(grant), 32'b0100);
    chk("D_no_done", 32'(done), 0);
    req = '0;
    run_to_done(100, loads, errs, dv, ead);
    chk("D_done", 32'(dv), 32'b0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
